// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI video transmitter.
package hdmi_pkg;

    // Width of one colour lane on the 36-bit output bus.
    localparam int LANE_W = 12;

    // Default 640x480 timing in pixel clocks / lines.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Output sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // True when lo <= val < hi.
    function automatic logic in_range(input int unsigned val,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/hdmi_video_tx_if.sv
// Push/pop bus between the transmitter sequencer and its pixel buffer.
interface hdmi_video_tx_if #(
    parameter int W = 25
) ();
    logic         push;
    logic [W-1:0] wdata;
    logic         full;
    logic         pop;
    logic [W-1:0] rdata;
    logic         empty;

    // Sequencer side: produces pushes and pops, observes buffer status.
    modport master (output push, output wdata, output pop,
                    input  full, input  empty, input  rdata);

    // Buffer side.
    modport slave  (input  push, input  wdata, input  pop,
                    output full, output empty, output rdata);
endinterface

// File: rtl/hdmi_fifo.sv
// First-word-fall-through pixel buffer: the head entry is always visible on
// rdata, so a word written into an empty buffer appears one cycle later.
module hdmi_fifo
    import hdmi_pkg::*;
#(
    parameter int W     = 25,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    hdmi_video_tx_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         full_s, empty_s, do_push_s, do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_s   = (wr_q == rd_q);
    assign full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push_s = bus.push && !full_s;
    assign do_pop_s  = bus.pop && !empty_s;

    assign bus.full  = full_s;
    assign bus.empty = empty_s;
    assign bus.rdata = mem_q[rd_q[AW-1:0]];

    // Next pointer values; a push and pop in the same cycle leave occupancy unchanged.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + PTR_ONE;
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + PTR_ONE;
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers with reset and flush to empty.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= bus.wdata;
        end
    end

endmodule

// File: rtl/hdmi_video_tx.sv
// HDMI video transmitter: buffers an incoming pixel stream, generates raster
// timing and aligns frames to the stream's start-of-frame marker.
module hdmi_video_tx
    import hdmi_pkg::*;
#(
    parameter int BPC        = 8,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [BPC-1:0] r,
    input  logic [BPC-1:0] g,
    input  logic [BPC-1:0] b,
    input  logic           sof,
    input  logic           video_valid,
    output logic           video_rdy,
    output logic [35:0]    HDMI_D,
    output logic           HDMI_DE,
    output logic           HDMI_HSYNC,
    output logic           HDMI_VSYNC,
    output logic           underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int PW      = 3 * BPC + 1;
    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);

    // Place a channel at the top of its lane, zero-filling the LSBs.
    function automatic logic [LANE_W-1:0] msb_align(input logic [BPC-1:0] c);
        return LANE_W'(c) << (LANE_W - BPC);
    endfunction

    hdmi_video_tx_if #(.W(PW)) fifo_bus ();

    state_e          state_q, state_d;
    logic [HCW-1:0]  h_q, h_d;
    logic [VCW-1:0]  v_q, v_d;
    logic [35:0]     d_q;
    logic            de_q, hs_q, vs_q, uf_q;
    logic            pop_s, show_s, uf_set_s;
    logic            active_s, origin_s, timing_on_s, head_sof_s;
    logic            hs_d, vs_d;
    logic [35:0]     pixel_s;

    hdmi_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (~en),
        .bus   (fifo_bus)
    );

    // Ready is held low in reset so the handshake matches the reset outputs.
    assign video_rdy      = en && rst && !fifo_bus.full;
    assign fifo_bus.push  = video_valid && video_rdy;
    assign fifo_bus.wdata = {sof, r, g, b};
    assign fifo_bus.pop   = pop_s;

    assign head_sof_s  = fifo_bus.rdata[PW-1];
    assign pixel_s     = {msb_align(fifo_bus.rdata[3*BPC-1 -: BPC]),
                          msb_align(fifo_bus.rdata[2*BPC-1 -: BPC]),
                          msb_align(fifo_bus.rdata[BPC-1 -: BPC])};
    assign timing_on_s = en && (state_q != ST_IDLE);
    assign active_s    = in_range(32'(h_q), 0, H_ACTIVE) && in_range(32'(v_q), 0, V_ACTIVE);
    assign origin_s    = (h_q == '0) && (v_q == '0);

    // Raster counters: held at zero while idle or disabled, free-running otherwise.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (timing_on_s) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VCW'(1);
            end else begin
                h_d = h_q + HCW'(1);
                v_d = v_q;
            end
        end else begin
            h_d = '0;
            v_d = '0;
        end
    end

    // Sync levels for the current counter position, inactive while idle.
    always_comb begin
        hs_d = ~HS_POL;
        vs_d = ~VS_POL;
        if (timing_on_s && in_range(32'(h_q), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC)) begin
            hs_d = HS_POL;
        end else begin
            hs_d = ~HS_POL;
        end
        if (timing_on_s && in_range(32'(v_q), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC)) begin
            vs_d = VS_POL;
        end else begin
            vs_d = ~VS_POL;
        end
    end

    // Sequencer next state: discard until a start-of-frame pixel meets the
    // raster origin, then stream one pixel per active cycle until misaligned.
    always_comb begin
        state_d  = state_q;
        pop_s    = 1'b0;
        show_s   = 1'b0;
        uf_set_s = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (fifo_bus.empty) begin
                        state_d = ST_SYNC;
                    end else if (!head_sof_s) begin
                        pop_s = 1'b1;
                    end else if (origin_s) begin
                        pop_s   = 1'b1;
                        show_s  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_RUN: begin
                    if (!active_s) begin
                        state_d = ST_RUN;
                    end else if (fifo_bus.empty) begin
                        uf_set_s = 1'b1;
                        state_d  = ST_SYNC;
                    end else if (head_sof_s != origin_s) begin
                        // Frame marker out of place: drop lock, leave the head for SYNC.
                        state_d = ST_SYNC;
                    end else begin
                        pop_s  = 1'b1;
                        show_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs, all aligned to the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            d_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            d_q     <= show_s ? pixel_s : 36'd0;
            de_q    <= show_s;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            uf_q    <= en ? (uf_q | uf_set_s) : 1'b0;
        end
    end

    assign HDMI_D     = d_q;
    assign HDMI_DE    = de_q;
    assign HDMI_HSYNC = hs_q;
    assign HDMI_VSYNC = vs_q;
    assign underflow  = uf_q;

endmodule

// File: doc/hdmi_video_tx.md
HDMI_VIDEO_TX -- requirements
Module: hdmi_video_tx

Interface
REQ-001 SHALL take parameter BPC, default 8, giving bits per colour channel (legal values 8, 10, 12).
REQ-002 SHALL take parameters H_ACTIVE, H_FP, H_SYNC, H_BP, defaults 640/16/96/48, giving horizontal timing in pixel clocks.
REQ-003 SHALL take parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480/10/2/33, giving vertical timing in lines.
REQ-004 SHALL take parameters HS_POL and VS_POL, default 0, giving the active level of each sync.
REQ-005 SHALL take parameter FIFO_DEPTH, default 16, giving pixel buffer entries (power of 2, at least 4).
REQ-006 SHALL have the port clk, input, 1 bit: pixel clock, the block's only clock.
REQ-007 SHALL have the port rst, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have the port en, input, 1 bit: enable, driven from the IIC configuration-done signal.
REQ-009 SHALL have the ports r, g, b, inputs, BPC bits each: pixel colour.
REQ-010 SHALL have the port sof, input, 1 bit: marks the first pixel of a frame.
REQ-011 SHALL have the port video_valid, input, 1 bit: pixel, sof and colour inputs are valid.
REQ-012 SHALL have the port video_rdy, output, 1 bit: the block accepts a pixel this cycle.
REQ-013 SHALL have the port HDMI_D, output, 36 bits: pixel data, R in [35:24], G in [23:12], B in [11:0].
REQ-014 SHALL have the ports HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, outputs, 1 bit each: data-enable and syncs.
REQ-015 SHALL have the port underflow, output, 1 bit: sticky error flag.

Function
REQ-016 SHALL drive video_rdy = en AND NOT fifo_full, and push {sof,r,g,b} when video_valid AND video_rdy.
REQ-017 SHALL use a first-word-fall-through FIFO, so a pixel pushed into an empty FIFO is visible at the head on the next cycle.
REQ-018 SHALL, while en=1, run counters h_cnt over 0..H_TOTAL-1 and v_cnt over 0..V_TOTAL-1, where H_TOTAL and V_TOTAL are the sums of their four timing parameters.
REQ-019 SHALL increment v_cnt only when h_cnt wraps, and wrap v_cnt from V_TOTAL-1 to 0.
REQ-020 SHALL treat the active region as h_cnt<H_ACTIVE AND v_cnt<V_ACTIVE.
REQ-021 SHALL assert HSYNC (level HS_POL) while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise drive it to the inactive level.
REQ-022 SHALL assert VSYNC (level VS_POL) while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; otherwise drive it to the inactive level.
REQ-023 SHALL register all outputs, so outputs at cycle t+1 reflect counters at cycle t, with data, DE and syncs mutually aligned.
REQ-024 SHALL MSB-align each channel in its 12-bit lane and zero-fill the unused LSBs (for example, BPC=8 places R in [35:28] with [27:24]=0).
REQ-025 SHALL drive HDMI_D=0 whenever DE=0 or no pixel is popped.
REQ-026 SHALL implement the state machine IDLE, SYNC, RUN.
REQ-027 IDLE: SHALL hold counters at 0, hold the FIFO flushed, drive DE=0 and syncs inactive, and go to SYNC on the first cycle with en=1.
REQ-028 SHALL, from any state, go to IDLE on the next edge when en=0, flushing the FIFO and clearing underflow.
REQ-029 SYNC: SHALL emit normal timing with black pixels, and pop and discard every head entry whose sof=0.
REQ-030 SYNC: SHALL keep an sof=1 head entry and go to RUN at (h_cnt,v_cnt)=(0,0) with that head present, popping it as the frame's first active pixel.
REQ-031 RUN: SHALL pop one entry per active-region cycle and drive it onto HDMI_D.
REQ-032 RUN: SHALL, if the FIFO is empty in an active cycle, output black, set underflow, and go to SYNC.
REQ-033 RUN: SHALL, if the head has sof=1 at an active position other than (0,0), not pop it, output black, and go to SYNC.
REQ-034 RUN: SHALL, if the head has sof=0 at (0,0), output black and go to SYNC.
REQ-035 SHALL give a simultaneous push and pop on a non-empty FIFO a net occupancy change of 0.
REQ-036 SHALL never push while full and never pop while empty.

Reset
REQ-037 SHALL, with rst=0 at a clk edge, set state to IDLE, counters to 0, and the FIFO to empty.
REQ-038 SHALL, with rst=0 at a clk edge, drive HDMI_D=0, DE=0, HSYNC=!HS_POL, VSYNC=!VS_POL, underflow=0 and video_rdy=0.
REQ-039 SHALL hold these reset values for the whole time rst=0.
REQ-040 SHALL apply a mid-frame reset on the next edge and discard any partial frame.

Structure
REQ-041 SHALL place the state enum, the lane width constant 12 and the default 640x480 timing constants in the shared package hdmi_pkg.
REQ-042 SHALL implement the FWFT buffer as the sub-module hdmi_fifo, parameterised on width and depth.

Verification
All scenarios use H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), BPC=8, FIFO_DEPTH=16.
REQ-043 SHALL cover: reset released, en=1, no pixels -> DE never high, HSYNC low at h_cnt 5..6, VSYNC low on line 4, HDMI_D=0, underflow=0.
REQ-044 SHALL cover: 12 pixels pushed before frame start, first with sof=1, R=0xA5 -> HDMI_D[35:24]=0xA50 on the first DE cycle, 4 DE cycles per line on 3 lines.
REQ-045 SHALL cover: 3 pixels pushed, then stall -> 4th active cycle has HDMI_D=0 and underflow=1; black output until the next sof-aligned frame.
REQ-046 SHALL cover: junk sof=0 pixels pushed before an sof pixel -> junk discarded; RUN starts at the next (0,0) with the sof pixel.
REQ-047 SHALL cover: BPC=10 with R=0x3FF -> HDMI_D[35:24]=0xFFC.
REQ-048 SHALL cover: en dropped mid-line -> next edge DE=0, syncs inactive, video_rdy=0, underflow cleared, FIFO empty.
